// File: rtl/bus_master_if.sv
// Requester agent for the shared 4-master bus: one local request becomes req/grant, one strobe, then wait for ready.
// A cycle counter started at the strobe releases the bus with err if the slave never answers.
module bus_master_if #(
   parameter int ADDR_W  = 30,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_en,
   input  logic              req_rw,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wr_data,
   output logic              req_busy,
   output logic [DATA_W-1:0] rd_data,
   output logic              done,
   output logic              err,
   output logic              bus_req_,
   input  logic              bus_grnt_,
   output logic [ADDR_W-1:0] bus_addr,
   output logic              bus_as_,
   output logic              bus_rw,
   output logic [DATA_W-1:0] bus_wr_data,
   input  logic [DATA_W-1:0] bus_rd_data,
   input  logic              bus_rdy_
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_REQ    = 2'd1;
   localparam logic [1:0] S_ACCESS = 2'd2;
   localparam logic [1:0] S_WAIT   = 2'd3;

   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

   logic [1:0]        state_q, state_d;
   logic [15:0]       cnt_q, cnt_d;
   logic              hold_rw_q, hold_rw_d;
   logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
   logic [DATA_W-1:0] hold_wd_q, hold_wd_d;
   logic              bus_req_n_q, bus_req_n_d;
   logic              bus_as_n_q, bus_as_n_d;
   logic              bus_rw_q, bus_rw_d;
   logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
   logic [DATA_W-1:0] bus_wd_q, bus_wd_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      hold_rw_d   = hold_rw_q;
      hold_addr_d = hold_addr_q;
      hold_wd_d   = hold_wd_q;
      bus_req_n_d = bus_req_n_q;
      bus_as_n_d  = bus_as_n_q;
      bus_rw_d    = bus_rw_q;
      bus_addr_d  = bus_addr_q;
      bus_wd_d    = bus_wd_q;
      rd_data_d   = rd_data_q;
      done_d      = 1'b0;
      err_d       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (req_en) begin
               hold_rw_d   = req_rw;
               hold_addr_d = req_addr;
               hold_wd_d   = req_wr_data;
               bus_req_n_d = 1'b0;
               state_d     = S_REQ;
            end
         end
         S_REQ: begin
            if (!bus_grnt_) begin
               bus_as_n_d = 1'b0;
               bus_addr_d = hold_addr_q;
               bus_rw_d   = hold_rw_q;
               bus_wd_d   = hold_wd_q;
               cnt_d      = '0;
               state_d    = S_ACCESS;
            end
         end
         default: begin
            // ACCESS is the strobe cycle; ready is already sampled at its closing edge.
            // The counter holds the number of cycles elapsed since the strobe began.
            if (!bus_rdy_ || cnt_q == CNT_LAST) begin
               done_d      = 1'b1;
               err_d       = bus_rdy_;
               rd_data_d   = !bus_rdy_ ? (hold_rw_q ? bus_rd_data : rd_data_q) : '0;
               bus_req_n_d = 1'b1;
               bus_as_n_d  = 1'b1;
               bus_addr_d  = '0;
               bus_rw_d    = 1'b1;
               bus_wd_d    = '0;
               state_d     = S_IDLE;
            end else begin
               bus_as_n_d = 1'b1;
               cnt_d      = cnt_q + 16'd1;
               state_d    = S_WAIT;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         hold_rw_q   <= 1'b1;
         hold_addr_q <= '0;
         hold_wd_q   <= '0;
         bus_req_n_q <= 1'b1;
         bus_as_n_q  <= 1'b1;
         bus_rw_q    <= 1'b1;
         bus_addr_q  <= '0;
         bus_wd_q    <= '0;
         rd_data_q   <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         hold_rw_q   <= hold_rw_d;
         hold_addr_q <= hold_addr_d;
         hold_wd_q   <= hold_wd_d;
         bus_req_n_q <= bus_req_n_d;
         bus_as_n_q  <= bus_as_n_d;
         bus_rw_q    <= bus_rw_d;
         bus_addr_q  <= bus_addr_d;
         bus_wd_q    <= bus_wd_d;
         rd_data_q   <= rd_data_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign req_busy    = (state_q != S_IDLE);
   assign rd_data     = rd_data_q;
   assign done        = done_q;
   assign err         = err_q;
   assign bus_req_    = bus_req_n_q;
   assign bus_as_     = bus_as_n_q;
   assign bus_rw      = bus_rw_q;
   assign bus_addr    = bus_addr_q;
   assign bus_wr_data = bus_wd_q;

endmodule
